// File: rtl/serial_frame_tx_if.sv
// Handshake and line signals between the CPU-side port logic and the framed
// serial transmitter.
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             left;
    logic             ready;
    logic             serial;
    logic             shift;
    logic             busy;
    logic             done;

    modport master (
        output data, valid, left,
        input  ready, serial, shift, busy, done
    );

    modport slave (
        input  data, valid, left,
        output ready, serial, shift, busy, done
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, WIDTH data bits, stop bit,
// each held DIV clocks, with a mid-bit strobe usable as a receiver shift enable.
module serial_frame_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic               clock,
    input  logic               reset_L,
    serial_frame_tx_if.slave   tx
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             left_q,  left_d;
    logic             done_q,  done_d;

    logic             last_div;
    logic             last_bit;

    assign last_div = (div_q == DIV_W'(DIV - 1));
    assign last_bit = (bit_q == BIT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        left_d  = left_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx.valid) begin
                    shreg_d = tx.data;
                    left_d  = tx.left;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (last_div) begin
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (last_div) begin
                    div_d   = '0;
                    // Advance so the next bit to send sits at the output end.
                    shreg_d = left_q ? (shreg_q >> 1) : (shreg_q << 1);
                    if (last_bit) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                if (last_div) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            left_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            left_q  <= left_d;
            done_q  <= done_d;
        end
    end

    // Outputs depend only on registered state, so the line cannot glitch mid-bit.
    always_comb begin
        tx.serial = 1'b1;
        case (state_q)
            ST_START: tx.serial = 1'b0;
            ST_DATA:  tx.serial = left_q ? shreg_q[0] : shreg_q[WIDTH-1];
            default:  tx.serial = 1'b1;
        endcase
    end

    assign tx.ready = (state_q == ST_IDLE);
    assign tx.busy  = (state_q != ST_IDLE);
    assign tx.shift = (state_q == ST_DATA) && (div_q == DIV_W'(DIV / 2));
    assign tx.done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx (WIDTH=8, DIV=4) with a receiving shift
// register clocked by the transmitter's shift strobe.
module tb_serial_frame_tx;
    localparam int WIDTH = 8;
    localparam int DIV   = 4;
    localparam int FRAME = (WIDTH + 2) * DIV;

    logic clock   = 1'b0;
    logic reset_L = 1'b0;

    int checks = 0;
    int errors = 0;

    serial_frame_tx_if #(.WIDTH(WIDTH)) tx_if ();

    serial_frame_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .tx      (tx_if)
    );

    always #5 clock = ~clock;

    // Receiver: same shift direction convention as the SIPO on the far end.
    logic [WIDTH-1:0] sipo_q = '0;
    logic             sipo_left = 1'b1;
    always @(posedge clock) begin
        if (tx_if.shift) begin
            if (sipo_left) sipo_q <= {tx_if.serial, sipo_q[WIDTH-1:1]};
            else           sipo_q <= {sipo_q[WIDTH-2:0], tx_if.serial};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a word and returns just after the posedge that accepts it.
    task automatic start_frame(input logic [WIDTH-1:0] w, input logic l, input logic hold);
        @(negedge clock);
        chk("ready_before_accept", tx_if.ready, 1'b1);
        tx_if.data  = w;
        tx_if.left  = l;
        tx_if.valid = 1'b1;
        sipo_left   = l;
        @(posedge clock);
        #1;
        if (!hold) tx_if.valid = 1'b0;
    endtask

    // Checks every cycle of a frame and the first idle cycle after it.
    // rx_seq collects line bits at each strobe, first bit in the MSB.
    task automatic check_frame(input logic [WIDTH-1:0] w, input logic l,
                               output logic [WIDTH-1:0] rx_seq);
        int  npulse;
        int  idx;
        logic exp_ser;
        logic exp_shf;
        npulse = 0;
        rx_seq = '0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clock);
            exp_shf = 1'b0;
            if (c < DIV) begin
                exp_ser = 1'b0;
            end else if (c < (WIDTH + 1) * DIV) begin
                idx     = (c - DIV) / DIV;
                exp_ser = l ? w[idx] : w[WIDTH - 1 - idx];
                exp_shf = (((c - DIV) % DIV) == DIV / 2);
            end else begin
                exp_ser = 1'b1;
            end
            chk("serial", tx_if.serial, exp_ser);
            chk("shift", tx_if.shift, exp_shf);
            chk("ready_low", tx_if.ready, 1'b0);
            chk("busy_high", tx_if.busy, 1'b1);
            chk("done_low", tx_if.done, 1'b0);
            if (tx_if.shift === 1'b1) begin
                npulse++;
                rx_seq = {rx_seq[WIDTH-2:0], tx_if.serial};
            end
        end
        @(negedge clock);
        chk("shift_pulses", npulse, WIDTH);
        chk("idle_ready", tx_if.ready, 1'b1);
        chk("idle_serial", tx_if.serial, 1'b1);
        chk("done_pulse", tx_if.done, 1'b1);
        chk("sipo_word", sipo_q, w);
    endtask

    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] rw;
    logic             rl;

    initial begin
        tx_if.data  = '0;
        tx_if.valid = 1'b0;
        tx_if.left  = 1'b0;

        // Reset state and quiet idle
        #1;
        chk("rst_serial", tx_if.serial, 1'b1);
        chk("rst_ready", tx_if.ready, 1'b1);
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_serial", tx_if.serial, 1'b1);
            chk("idle_ready", tx_if.ready, 1'b1);
            chk("idle_busy", tx_if.busy, 1'b0);
            chk("idle_shift", tx_if.shift, 1'b0);
            chk("idle_done", tx_if.done, 1'b0);
        end
        $display("idle: 10 cycles checked");

        // A5 LSB first: line bits 1,0,1,0,0,1,0,1
        start_frame(8'hA5, 1'b1, 1'b0);
        check_frame(8'hA5, 1'b1, rx);
        chk("a5_lsb_bits", rx, 8'b1010_0101);
        @(negedge clock);
        chk("done_once", tx_if.done, 1'b0);
        $display("frame A5 left=1 rx_seq=%02h", rx);

        // A5 MSB first is the same sequence; 01 MSB first ends with the only 1
        start_frame(8'hA5, 1'b0, 1'b0);
        check_frame(8'hA5, 1'b0, rx);
        chk("a5_msb_bits", rx, 8'b1010_0101);
        $display("frame A5 left=0 rx_seq=%02h", rx);
        start_frame(8'h01, 1'b0, 1'b0);
        check_frame(8'h01, 1'b0, rx);
        chk("01_msb_bits", rx, 8'b0000_0001);
        $display("frame 01 left=0 rx_seq=%02h", rx);

        // Loopback with random words and bit order
        for (int n = 0; n < 50; n++) begin
            rw = WIDTH'($urandom);
            rl = 1'($urandom_range(0, 1));
            start_frame(rw, rl, 1'b0);
            check_frame(rw, rl, rx);
            $display("loopback %0d: word=%02h left=%0d sipo=%02h", n, rw, rl, sipo_q);
        end

        // Back-to-back with valid held; data changes mid-frame are ignored
        start_frame(8'h3C, 1'b0, 1'b1);
        tx_if.data = 8'hC3;
        check_frame(8'h3C, 1'b0, rx);
        chk("b2b_first_bits", rx, 8'h3C);
        @(posedge clock);
        #1;
        tx_if.valid = 1'b0;
        check_frame(8'hC3, 1'b0, rx);
        chk("b2b_second_bits", rx, 8'hC3);
        $display("back-to-back 3C then C3: second rx_seq=%02h", rx);

        // Asynchronous reset during data bit 3
        start_frame(8'h00, 1'b1, 1'b0);
        repeat (DIV + 3 * DIV + 2) @(negedge clock);
        chk("pre_reset_serial", tx_if.serial, 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_rst_serial", tx_if.serial, 1'b1);
        chk("async_rst_ready", tx_if.ready, 1'b1);
        chk("async_rst_busy", tx_if.busy, 1'b0);
        chk("async_rst_shift", tx_if.shift, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_no_done", tx_if.done, 1'b0);
        end
        reset_L = 1'b1;
        @(negedge clock);
        chk("post_rst_done", tx_if.done, 1'b0);
        start_frame(8'h96, 1'b1, 1'b0);
        check_frame(8'h96, 1'b1, rx);
        chk("post_rst_bits", rx, 8'b0110_1001);
        $display("after reset: frame 96 left=1 rx_seq=%02h", rx);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
